// File: rtl/y86_seq_ctrl_pkg.sv
// Shared Y86 definitions: controller states, status codes and opcode constants.
package y86_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_PCUPD     = 3'd6,
    ST_HALT      = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    STAT_AOK = 2'b00,
    STAT_HLT = 2'b01,
    STAT_ADR = 2'b10,
    STAT_INS = 2'b11
  } stat_e;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Instructions that touch data memory and therefore visit the MEMORY stage.
  function automatic logic uses_dmem(input logic [3:0] icode);
    case (icode)
      I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/y86_seq_ctrl_if.sv
// Control/status bundle between the sequencer and the datapath.
interface y86_seq_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             step;
  logic [3:0]       icode;
  logic             instr_valid;
  logic             imem_err;
  logic             dmem_err;
  logic             dmem_ready;
  logic             fetch_en;
  logic             dec_en;
  logic             exe_en;
  logic             mem_en;
  logic             wb_en;
  logic             pc_en;
  logic             busy;
  logic [1:0]       stat;
  logic [CNT_W-1:0] retired;

  // Datapath / environment side: drives the status inputs, receives strobes.
  modport master (
    output start, step, icode, instr_valid, imem_err, dmem_err, dmem_ready,
    input  fetch_en, dec_en, exe_en, mem_en, wb_en, pc_en, busy, stat, retired
  );

  // Controller side.
  modport slave (
    input  start, step, icode, instr_valid, imem_err, dmem_err, dmem_ready,
    output fetch_en, dec_en, exe_en, mem_en, wb_en, pc_en, busy, stat, retired
  );
endinterface

// File: rtl/y86_seq_ctrl_mem_wait_timer.sv
// Counts MEMORY-stage wait cycles; expired flags the last permitted cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 2);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins; otherwise count enabled cycles, holding at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter starts at 0 on the first MEMORY cycle, so reaching TIMEOUT means
  // TIMEOUT+1 cycles have been spent waiting.
  assign expired = (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/y86_seq_ctrl.sv
// Y86 sequential-processor stage controller: walks one instruction through
// FETCH..PCUPD, tracks fault status and counts retired instructions.
module y86_seq_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic           clk,
  input  logic           rst,
  y86_seq_ctrl_if.slave  bus
);
  import y86_seq_ctrl_pkg::*;

  state_e           state_q, state_d;
  stat_e            stat_q, stat_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             tmr_clear;
  logic             tmr_en;
  logic             tmr_expired;

  // Timer runs only while in MEMORY and is held at zero everywhere else, so
  // every MEMORY entry starts a fresh wait window.
  assign tmr_en    = (state_q == ST_MEMORY);
  assign tmr_clear = (state_q != ST_MEMORY);

  mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  // Next-state, fault status and retire-count logic.
  always_comb begin
    state_d   = state_q;
    stat_d    = stat_q;
    retired_d = retired_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_err) begin
          state_d = ST_HALT;
          stat_d  = STAT_ADR;
        end else if (!bus.instr_valid) begin
          state_d = ST_HALT;
          stat_d  = STAT_INS;
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        state_d = uses_dmem(bus.icode) ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        // A data fault beats completion; completion beats the timeout, so a
        // ready arriving on the final permitted cycle still succeeds.
        if (bus.dmem_err) begin
          state_d = ST_HALT;
          stat_d  = STAT_ADR;
        end else if (bus.dmem_ready) begin
          state_d = ST_WRITEBACK;
        end else if (tmr_expired) begin
          state_d = ST_HALT;
          stat_d  = STAT_ADR;
        end
      end
      ST_WRITEBACK: state_d = ST_PCUPD;
      ST_PCUPD: begin
        retired_d = retired_q + CNT_W'(1);
        if (bus.icode == I_HALT) begin
          state_d = ST_HALT;
          stat_d  = STAT_HLT;
        end else if (bus.step) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, status and counter registers; reset acts immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      stat_q    <= STAT_AOK;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      stat_q    <= stat_d;
      retired_q <= retired_d;
    end
  end

  // Stage strobes and busy are decoded from the state register only.
  always_comb begin
    bus.fetch_en = (state_q == ST_FETCH);
    bus.dec_en   = (state_q == ST_DECODE);
    bus.exe_en   = (state_q == ST_EXECUTE);
    bus.mem_en   = (state_q == ST_MEMORY);
    bus.wb_en    = (state_q == ST_WRITEBACK);
    bus.pc_en    = (state_q == ST_PCUPD);
    bus.busy     = (state_q != ST_IDLE) && (state_q != ST_HALT);
  end

  assign bus.stat    = stat_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Self-checking bench for y86_seq_ctrl: expected stage strobes are queued as
// each instruction is launched and popped one per clock.
module tb_y86_seq_ctrl;
  import y86_seq_ctrl_pkg::*;

  localparam int CW = 4;
  localparam logic [5:0] SF = 6'b100000;
  localparam logic [5:0] SD = 6'b010000;
  localparam logic [5:0] SE = 6'b001000;
  localparam logic [5:0] SM = 6'b000100;
  localparam logic [5:0] SW = 6'b000010;
  localparam logic [5:0] SP = 6'b000001;
  localparam logic [5:0] SN = 6'b000000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  y86_seq_ctrl_if #(.CNT_W(CW)) bus ();

  y86_seq_ctrl #(
    .MEM_TIMEOUT (15),
    .CNT_W       (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [5:0]  obs;
  logic [5:0]  exp_s;
  logic [5:0]  exp_q[$];
  logic [CW-1:0] ret_q[$];
  int          mem_k;
  int          ready_after;
  int          err_at;

  function automatic logic [5:0] sample();
    return {bus.fetch_en, bus.dec_en, bus.exe_en, bus.mem_en, bus.wb_en, bus.pc_en};
  endfunction

  // One clock: memory handshake inputs follow the MEMORY cycle number.
  task automatic cycle();
    bus.dmem_ready = (obs == SM) && (mem_k > ready_after);
    bus.dmem_err   = (obs == SM) && (mem_k == err_at);
    @(posedge clk);
    @(negedge clk);
    obs = sample();
    if (obs == SM) mem_k++; else mem_k = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0; bus.step = 1'b0; bus.icode = I_NOP; bus.instr_valid = 1'b1;
    bus.imem_err = 1'b0; bus.dmem_err = 1'b0; bus.dmem_ready = 1'b0;
    ready_after = 0; err_at = 0;
    @(negedge clk);
    rst = 1'b1;
    obs = sample();
    mem_k = 0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) exp_q.push_back(SN);
    while (exp_q.size() > 0) begin
      exp_s = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_s || bus.busy !== 1'b0 || bus.stat !== STAT_AOK || bus.retired !== '0) begin
        n_errs++;
        $display("FAIL reset_idle: strobes=%b busy=%b stat=%b retired=%0d expected strobes=%b busy=0 stat=00 retired=0",
                 obs, bus.busy, bus.stat, bus.retired, exp_s);
      end
      cycle();
    end
  endtask

  task automatic test_alu();
    do_reset();
    bus.icode = I_OPQ;
    exp_q = '{SF, SD, SE, SW, SP, SF};
    start_pulse();
    while (exp_q.size() > 0) begin
      exp_s = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_s || bus.busy !== (exp_s != SN)) begin
        n_errs++;
        $display("FAIL alu_seq: strobes=%b busy=%b expected %b", obs, bus.busy, exp_s);
      end
      if (exp_q.size() > 0) cycle();
    end
    n_checks++;
    if (bus.retired !== CW'(1) || bus.stat !== STAT_AOK) begin
      n_errs++;
      $display("FAIL alu_retired: retired=%0d stat=%b expected 1 00", bus.retired, bus.stat);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    bus.icode = I_MRMOVQ;
    ready_after = 3;
    exp_q = '{SF, SD, SE, SM, SM, SM, SM, SW, SP, SF};
    start_pulse();
    while (exp_q.size() > 0) begin
      exp_s = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_s) begin
        n_errs++;
        $display("FAIL mem_wait: strobes=%b expected %b", obs, exp_s);
      end
      if (exp_q.size() > 0) cycle();
    end
    n_checks++;
    if (bus.retired !== CW'(1)) begin
      n_errs++;
      $display("FAIL mem_retired: retired=%0d expected 1", bus.retired);
    end
  endtask

  task automatic test_icode_routing();
    for (int ic = 1; ic < 16; ic++) begin
      do_reset();
      bus.icode = 4'(ic);
      exp_q = '{SF, SD, SE};
      if (ic inside {4, 5, 8, 9, 10, 11}) exp_q.push_back(SM);
      exp_q.push_back(SW);
      exp_q.push_back(SP);
      exp_q.push_back(SF);
      start_pulse();
      while (exp_q.size() > 0) begin
        exp_s = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_s) begin
          n_errs++;
          $display("FAIL route_icode_%0h: strobes=%b expected %b", ic, obs, exp_s);
        end
        if (exp_q.size() > 0) cycle();
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    bus.icode = I_HALT;
    exp_q = '{SF, SD, SE, SW, SP, SN};
    start_pulse();
    while (exp_q.size() > 0) begin
      exp_s = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_s) begin
        n_errs++;
        $display("FAIL halt_seq: strobes=%b expected %b", obs, exp_s);
      end
      if (exp_q.size() > 0) cycle();
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (obs !== SN || bus.busy !== 1'b0 || bus.stat !== STAT_HLT || bus.retired !== CW'(1)) begin
        n_errs++;
        $display("FAIL halt_absorb: strobes=%b busy=%b stat=%b retired=%0d expected 000000 0 01 1",
                 obs, bus.busy, bus.stat, bus.retired);
      end
      start_pulse();
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (sample() !== SN || bus.stat !== STAT_AOK || bus.retired !== '0 || bus.busy !== 1'b0) begin
      n_errs++;
      $display("FAIL halt_reset: strobes=%b stat=%b retired=%0d expected 000000 00 0",
               sample(), bus.stat, bus.retired);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_faults();
    // Step-mode retire first, then a fetch address fault that also has instr_valid low.
    do_reset();
    bus.step = 1'b1;
    exp_q = '{SF, SD, SE, SW, SP, SN};
    start_pulse();
    while (exp_q.size() > 0) begin
      exp_s = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_s) begin
        n_errs++;
        $display("FAIL fault_pre: strobes=%b expected %b", obs, exp_s);
      end
      if (exp_q.size() > 0) cycle();
    end
    bus.imem_err = 1'b1; bus.instr_valid = 1'b0;
    start_pulse();
    cycle();
    n_checks++;
    if (obs !== SN || bus.stat !== STAT_ADR || bus.retired !== CW'(1)) begin
      n_errs++;
      $display("FAIL imem_fault: strobes=%b stat=%b retired=%0d expected 000000 10 1", obs, bus.stat, bus.retired);
    end
    // Illegal opcode only.
    do_reset();
    bus.instr_valid = 1'b0;
    start_pulse();
    cycle();
    n_checks++;
    if (obs !== SN || bus.stat !== STAT_INS || bus.retired !== '0) begin
      n_errs++;
      $display("FAIL ins_fault: strobes=%b stat=%b retired=%0d expected 000000 11 0", obs, bus.stat, bus.retired);
    end
    // Timeout (16 MEMORY cycles), data fault beating ready, and ready on the last cycle.
    for (int sc = 0; sc < 3; sc++) begin
      do_reset();
      bus.icode = (sc == 1) ? I_RMMOVQ : I_MRMOVQ;
      ready_after = (sc == 0) ? 1000 : (sc == 1) ? 1 : 15;
      err_at = (sc == 1) ? 2 : 0;
      exp_q = '{SF, SD, SE};
      repeat ((sc == 1) ? 2 : 16) exp_q.push_back(SM);
      if (sc == 2) begin
        exp_q.push_back(SW); exp_q.push_back(SP); exp_q.push_back(SF);
      end else begin
        exp_q.push_back(SN);
      end
      start_pulse();
      while (exp_q.size() > 0) begin
        exp_s = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_s) begin
          n_errs++;
          $display("FAIL mem_case_%0d: strobes=%b expected %b", sc, obs, exp_s);
        end
        if (exp_q.size() > 0) cycle();
      end
      n_checks++;
      if (bus.stat !== ((sc == 2) ? STAT_AOK : STAT_ADR) || bus.retired !== ((sc == 2) ? CW'(1) : CW'(0))) begin
        n_errs++;
        $display("FAIL mem_case_%0d_stat: stat=%b retired=%0d", sc, bus.stat, bus.retired);
      end
    end
  endtask

  task automatic test_step();
    do_reset();
    bus.step = 1'b1;
    bus.icode = I_RRMOVQ;
    for (int n = 1; n <= 2; n++) begin
      exp_q = '{SF, SD, SE, SW, SP, SN, SN, SN};
      start_pulse();
      while (exp_q.size() > 0) begin
        exp_s = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_s || bus.busy !== (exp_s != SN)) begin
          n_errs++;
          $display("FAIL step_%0d: strobes=%b busy=%b expected %b", n, obs, bus.busy, exp_s);
        end
        if (exp_q.size() > 0) cycle();
      end
      n_checks++;
      if (bus.retired !== CW'(n) || bus.stat !== STAT_AOK) begin
        n_errs++;
        $display("FAIL step_retired_%0d: retired=%0d stat=%b expected %0d 00", n, bus.retired, bus.stat, n);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.step = 1'b1;
    bus.icode = I_OPQ;
    exp_q = '{SF, SD, SE, SW, SP, SN};
    start_pulse();
    while (exp_q.size() > 0) begin
      exp_s = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_s) begin
        n_errs++;
        $display("FAIL rmid_pre: strobes=%b expected %b", obs, exp_s);
      end
      if (exp_q.size() > 0) cycle();
    end
    bus.step = 1'b0;
    bus.icode = I_MRMOVQ;
    ready_after = 1000;
    exp_q = '{SF, SD, SE, SM, SM};
    start_pulse();
    while (exp_q.size() > 0) begin
      exp_s = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_s || bus.retired !== CW'(1)) begin
        n_errs++;
        $display("FAIL rmid_run: strobes=%b retired=%0d expected %b 1", obs, bus.retired, exp_s);
      end
      if (exp_q.size() > 0) cycle();
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (sample() !== SN || bus.busy !== 1'b0 || bus.retired !== '0 || bus.stat !== STAT_AOK) begin
      n_errs++;
      $display("FAIL rmid_async: strobes=%b busy=%b retired=%0d stat=%b expected 000000 0 0 00",
               sample(), bus.busy, bus.retired, bus.stat);
    end
    @(negedge clk);
    rst = 1'b1;
    obs = sample();
    repeat (2) cycle();
    n_checks++;
    if (obs !== SN) begin
      n_errs++;
      $display("FAIL rmid_nostart: strobes=%b expected 000000", obs);
    end
  endtask

  task automatic test_back_to_back();
    int nf;
    do_reset();
    bus.icode = I_NOP;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(SF); exp_q.push_back(SD); exp_q.push_back(SE);
      exp_q.push_back(SW); exp_q.push_back(SP);
      ret_q.push_back(CW'((i + 1) % 16));
    end
    exp_q.push_back(SF);
    nf = 0;
    start_pulse();
    while (exp_q.size() > 0) begin
      exp_s = exp_q.pop_front();
      n_checks++;
      if (obs !== exp_s) begin
        n_errs++;
        $display("FAIL b2b_strobe: strobes=%b expected %b", obs, exp_s);
      end
      if (exp_s == SF && nf > 0 && ret_q.size() > 0) begin
        logic [CW-1:0] er;
        er = ret_q.pop_front();
        n_checks++;
        if (bus.retired !== er) begin
          n_errs++;
          $display("FAIL b2b_retired: retired=%0d expected %0d", bus.retired, er);
        end
      end
      if (exp_s == SF) nf++;
      if (exp_q.size() > 0) cycle();
    end
    n_checks++;
    if (bus.retired !== '0 || ret_q.size() != 0) begin
      n_errs++;
      $display("FAIL b2b_wrap: retired=%0d pending=%0d expected 0 0", bus.retired, ret_q.size());
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.step = 1'b0; bus.icode = I_NOP; bus.instr_valid = 1'b1;
    bus.imem_err = 1'b0; bus.dmem_err = 1'b0; bus.dmem_ready = 1'b0;
    obs = SN; mem_k = 0; ready_after = 0; err_at = 0;
    test_reset();
    test_alu();
    test_mem_wait();
    test_icode_routing();
    test_halt();
    test_faults();
    test_step();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/y86_seq_ctrl.md
Y86_SEQ_CTRL -- requirements
Module: y86_seq_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15: maximum MEMORY-stage wait cycles before an ADR fault.
REQ-002 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; begins execution from IDLE.
REQ-006 step  input  1  level; when 1, run one instruction per start pulse.
REQ-007 icode  input  4  opcode of the instruction being decoded.
REQ-008 instr_valid  input  1  fetched opcode is legal.
REQ-009 imem_err  input  1  instruction memory address fault.
REQ-010 dmem_err  input  1  data memory address fault, sampled in MEMORY.
REQ-011 dmem_ready  input  1  data memory access complete.
REQ-012 fetch_en, dec_en, exe_en, mem_en, wb_en, pc_en  output  1 each  one-hot stage strobes.
REQ-013 busy  output  1  controller is between IDLE and HALT.
REQ-014 stat  output  2  00 AOK, 01 HLT, 10 ADR, 11 INS.
REQ-015 retired  output  CNT_W  count of instructions whose PCUPD completed.

Function
REQ-016 SHALL implement states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD and HALT.
REQ-017 SHALL assert exactly one stage strobe per cycle, corresponding to the current state: FETCH→fetch_en through PCUPD→pc_en; all strobes 0 in IDLE and HALT.
REQ-018 IDLE→FETCH on start=1; start is ignored in every other state.
REQ-019 FETCH→HALT with stat=10 if imem_err=1; →HALT with stat=11 if instr_valid=0; otherwise →DECODE; imem_err takes priority.
REQ-020 DECODE→EXECUTE unconditionally; EXECUTE→MEMORY when icode ∈ {4,5,8,9,A,B}, otherwise →WRITEBACK.
REQ-021 MEMORY holds mem_en high until dmem_ready=1, then →WRITEBACK; dmem_err=1 in any MEMORY cycle →HALT with stat=10, and it takes priority over dmem_ready.
REQ-022 A wait counter SHALL clear on MEMORY entry; if MEMORY_TIMEOUT cycles elapse without dmem_ready, →HALT with stat=10 (MEMORY held exactly MEM_TIMEOUT+1 cycles).
REQ-023 WRITEBACK→PCUPD unconditionally.
REQ-024 PCUPD SHALL increment retired, wrapping modulo 2^CNT_W; then if icode=0 →HALT with stat=01; else if step=1 →IDLE; else →FETCH.
REQ-025 Faulting instructions SHALL never reach PCUPD and SHALL not increment retired.
REQ-026 HALT is absorbing; only rst exits it.
REQ-027 busy=1 in FETCH through PCUPD, 0 in IDLE and HALT.
REQ-028 Minimum instruction latency is 5 cycles (no MEMORY) or 6 cycles (MEMORY with dmem_ready on the first cycle), FETCH entry to PCUPD inclusive.
REQ-029 All outputs SHALL be registered or decoded purely from state; no input→output combinational path.

Reset
REQ-030 rst=0 SHALL immediately force state IDLE, stat=00, retired=0, wait counter 0, all strobes 0 and busy=0, including mid-instruction and in HALT.
REQ-031 On rst release, the first transition SHALL occur only on a start pulse.

Structure
REQ-032 State encoding, stat codes (AOK/HLT/ADR/INS) and icode constants SHALL reside in the shared y86 package used by the fetch, data-memory and PC-update blocks.
REQ-033 The MEMORY wait/timeout counter SHALL be one sub-module, mem_wait_timer (clear, enable, expired).

Verification
REQ-034 Reset, start, then icode=6 with instr_valid=1 → strobes F,D,E,W,P on consecutive cycles, FETCH again, retired=1.
REQ-035 icode=5 with dmem_ready high after 3 wait cycles → mem_en high for 4 cycles, then WRITEBACK, retired increments.
REQ-036 icode=0 → PCUPD then HALT, stat=01, busy=0; subsequent start pulses are ignored.
REQ-037 imem_err=1 and instr_valid=0 in FETCH → HALT, stat=10, retired unchanged; dmem_ready never asserted with MEM_TIMEOUT=15 → HALT after 16 MEMORY cycles, stat=10.
REQ-038 step=1 → one instruction per start pulse, returning to IDLE; rst=0 asserted during MEMORY → IDLE, retired=0, all strobes 0 asynchronously.
REQ-039 CNT_W=4 with 16 retired instructions → retired wraps to 0.
